// File: rtl/div11_reconstruct.sv
// Digit-serial reconstruction x = 11*q + r for the divide-by-11 datapath, DIGIT_W quotient bits per cycle.
// Optional self-check against an expected dividend is enabled by defining DIV11_CHECK_EN.
module div11_reconstruct #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_q,
  input  logic [3:0]  in_r,
`ifdef DIV11_CHECK_EN
  input  logic [63:0] in_x_exp,
  output logic        out_mismatch,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_x,
  output logic        out_ovf,
  output logic        out_rem_err
);

  localparam int unsigned X_W   = 64;
  localparam int unsigned N     = X_W / DIGIT_W;
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned C_W   = 4;
  localparam int unsigned S_W   = DIGIT_W + C_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [X_W-1:0]     q_sr;
  logic [X_W-1:0]     res_sr;
  logic [C_W-1:0]     carry;
  logic [CNT_W-1:0]   cnt;
`ifdef DIV11_CHECK_EN
  logic [X_W-1:0]     x_exp_q;
`endif

  logic [DIGIT_W-1:0] d;
  logic [S_W-1:0]     s;
  logic [C_W-1:0]     s_hi;
  logic [X_W-1:0]     res_next;
  logic               last;

  // One digit step: 11*d + carry never needs more than DIGIT_W+4 bits for carry <= 15.
  always_comb begin
    d        = q_sr[DIGIT_W-1:0];
    s        = S_W'(d) * S_W'(11) + S_W'(carry);
    s_hi     = s[S_W-1:DIGIT_W];
    res_next = {s[DIGIT_W-1:0], res_sr[X_W-1:DIGIT_W]};
    last     = (cnt == CNT_W'(N - 1));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_sr        <= '0;
      res_sr      <= '0;
      carry       <= '0;
      cnt         <= '0;
      out_x       <= '0;
      out_ovf     <= 1'b0;
      out_rem_err <= 1'b0;
`ifdef DIV11_CHECK_EN
      x_exp_q      <= '0;
      out_mismatch <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_sr        <= in_q;
            carry       <= in_r;
            cnt         <= '0;
            out_rem_err <= (in_r > 4'd10);
`ifdef DIV11_CHECK_EN
            x_exp_q     <= in_x_exp;
`endif
            state       <= RUN;
          end
        end
        RUN: begin
          q_sr   <= q_sr >> DIGIT_W;
          res_sr <= res_next;
          carry  <= s_hi;
          cnt    <= cnt + CNT_W'(1);
          // Result is published only once complete so no partial value is ever visible.
          if (last) begin
            out_x   <= res_next;
            out_ovf <= (s_hi != '0);
`ifdef DIV11_CHECK_EN
            out_mismatch <= (res_next != x_exp_q) || (s_hi != '0);
`endif
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
